// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, stop bits, registered line.
// A one-entry holding register lets frames run back to back with no gap.
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int CYCLES_PER_SYMBOL = 125_000_000 / 115_200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 signal_out,
  output logic                 busy
);

  localparam int SW = $clog2(CYCLES_PER_SYMBOL + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(STOP_BITS + 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(CYCLES_PER_SYMBOL - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [PW-1:0] STOP_LAST = PW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shifter, shifter_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic [SW-1:0]        sym_cnt, sym_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [PW-1:0]        stop_cnt, stop_n;
  logic                 line_n;
  logic                 accept;
  logic                 tick;
  logic [DATA_BITS-1:0] shifted;

  assign data_ready = ~hold_full;
  assign busy       = (state != IDLE) | hold_full;
  assign accept     = data_valid & ~hold_full;
  assign tick       = (sym_cnt == SYM_LAST);
  assign shifted    = shifter >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      sym_cnt    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      signal_out <= 1'b1;
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      sym_cnt    <= sym_n;
      bit_cnt    <= bit_n;
      stop_cnt   <= stop_n;
      signal_out <= line_n;
    end
  end

  always_comb begin
    state_n     = state;
    shifter_n   = shifter;
    hold_n      = hold;
    hold_full_n = hold_full;
    bit_n       = bit_cnt;
    stop_n      = stop_cnt;
    line_n      = signal_out;
    sym_n       = '0;
    if (state != IDLE) begin
      sym_n = tick ? '0 : sym_cnt + 1'b1;
      if (accept) begin
        hold_n      = data_in;
        hold_full_n = 1'b1;
      end
    end
    unique case (state)
      IDLE: begin
        if (accept) begin
          shifter_n = data_in;
          state_n   = START;
          line_n    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          line_n  = shifter[0];
        end
      end
      DATA: begin
        if (tick) begin
          shifter_n = shifted;
          if (bit_cnt == BIT_LAST) begin
            bit_n   = '0;
            state_n = STOP;
            line_n  = 1'b1;
          end else begin
            bit_n  = bit_cnt + 1'b1;
            line_n = shifted[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            // Frame end: a pending byte wins; a direct accept bypasses hold.
            stop_n = '0;
            if (hold_full) begin
              shifter_n   = hold;
              hold_full_n = 1'b0;
              state_n     = START;
              line_n      = 1'b0;
            end else if (accept) begin
              shifter_n   = data_in;
              hold_full_n = 1'b0;
              state_n     = START;
              line_n      = 1'b0;
            end else begin
              state_n = IDLE;
              line_n  = 1'b1;
            end
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: C=4 instance plus a C=1,
// two-stop-bit instance decoded by a bench-side receiver.
`timescale 1ns/1ps
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       signal_out;
  logic       busy;
  logic [7:0] data_in2;
  logic       data_valid2;
  logic       data_ready2;
  logic       signal_out2;
  logic       busy2;

  int total = 0;
  int bad = 0;

  uart_transmitter #(
    .CYCLES_PER_SYMBOL(4),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .signal_out(signal_out),
    .busy(busy)
  );

  uart_transmitter #(
    .CYCLES_PER_SYMBOL(1),
    .DATA_BITS(8),
    .STOP_BITS(2)
  ) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in2),
    .data_valid(data_valid2),
    .data_ready(data_ready2),
    .signal_out(signal_out2),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles after the accept edge, 4 cycles/bit.
  function automatic logic fbit(input logic [7:0] d, input int k);
    int s;
    s = k / 4;
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    data_valid2 = 1'b0;
    data_in2 = 8'h00;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (signal_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_line got=%b exp=1", signal_out);
    end
    total++;
    if (data_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", data_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (signal_out !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle k=%0d line=%b busy=%b exp 1/0",
                 k, signal_out, busy);
      end
    end
  endtask

  task automatic test_frame;
    @(negedge clk);
    data_in = 8'hA5;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in = 8'h00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      total++;
      if (signal_out !== fbit(8'hA5, k) || busy !== 1'b1) begin
        bad++;
        $display("FAIL frame_a5 k=%0d line=%b busy=%b exp=%b/1",
                 k, signal_out, busy, fbit(8'hA5, k));
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || signal_out !== 1'b1) begin
      bad++;
      $display("FAIL frame_a5_end busy=%b line=%b exp 0/1", busy, signal_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [3];
    int idx;
    logic will;
    logic exp_rdy;
    b[0] = 8'h00;
    b[1] = 8'hFF;
    b[2] = 8'h3C;
    idx = 0;
    @(negedge clk);
    data_in = b[0];
    data_valid = 1'b1;
    will = data_ready;
    for (int k = 0; k <= 120; k++) begin
      @(negedge clk);
      if (k < 120) begin
        exp_rdy = !((k >= 1 && k < 40) || (k >= 41 && k < 80));
        total++;
        if (signal_out !== fbit(b[k/40], k % 40)) begin
          bad++;
          $display("FAIL b2b_line k=%0d got=%b exp=%b",
                   k, signal_out, fbit(b[k/40], k % 40));
        end
        total++;
        if (data_ready !== exp_rdy || busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready k=%0d rdy=%b busy=%b exp=%b/1",
                   k, data_ready, busy, exp_rdy);
        end
      end else begin
        total++;
        if (busy !== 1'b0 || signal_out !== 1'b1) begin
          bad++;
          $display("FAIL b2b_end busy=%b line=%b exp 0/1", busy, signal_out);
        end
      end
      if (will) begin
        idx++;
        if (idx < 3) data_in = b[idx];
        else data_valid = 1'b0;
      end
      will = data_valid & data_ready;
    end
    total++;
    if (idx != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=3", idx);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    data_in = 8'h00;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h7E;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (signal_out !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre line=%b rdy=%b busy=%b exp 0/0/1",
               signal_out, data_ready, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (signal_out !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset line=%b busy=%b rdy=%b exp 1/0/1",
               signal_out, busy, data_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (signal_out !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_after k=%0d line=%b busy=%b rdy=%b exp 1/0/1",
                 k, signal_out, busy, data_ready);
      end
    end
    data_in = 8'h81;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      total++;
      if (signal_out !== fbit(8'h81, k) || busy !== 1'b1) begin
        bad++;
        $display("FAIL frame_81 k=%0d line=%b busy=%b exp=%b/1",
                 k, signal_out, busy, fbit(8'h81, k));
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_81_end busy=%b exp=0", busy);
    end
  endtask

  task automatic test_frame_end_accept;
    logic e;
    @(negedge clk);
    data_in = 8'h5A;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      e = (k < 40) ? fbit(8'h5A, k) : fbit(8'hC3, k - 40);
      total++;
      if (signal_out !== e || busy !== 1'b1 || data_ready !== 1'b1) begin
        bad++;
        $display("FAIL end_accept k=%0d line=%b busy=%b rdy=%b exp=%b/1/1",
                 k, signal_out, busy, data_ready, e);
      end
      if (k == 39) begin
        data_in = 8'hC3;
        data_valid = 1'b1;
      end else if (k == 40) begin
        data_valid = 1'b0;
        data_in = 8'hFF;
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || signal_out !== 1'b1) begin
      bad++;
      $display("FAIL end_accept_idle busy=%b line=%b exp 0/1", busy, signal_out);
    end
  endtask

  task automatic test_loopback;
    int idx;
    int rx_pos;
    int rx_cnt;
    int errs;
    logic [7:0] rx_byte;
    logic will;
    idx = 0;
    rx_pos = 0;
    rx_cnt = 0;
    errs = 0;
    rx_byte = 8'h00;
    @(negedge clk);
    data_in2 = 8'h00;
    data_valid2 = 1'b1;
    will = data_ready2;
    for (int c = 0; c < 256 * 11 + 40 && rx_cnt < 256; c++) begin
      @(negedge clk);
      if (will) begin
        idx++;
        if (idx < 256) data_in2 = idx[7:0];
        else data_valid2 = 1'b0;
      end
      will = data_valid2 & data_ready2;
      if (rx_pos == 0) begin
        if (signal_out2 === 1'b0) rx_pos = 1;
      end else if (rx_pos <= 8) begin
        rx_byte[rx_pos-1] = signal_out2;
        rx_pos++;
      end else begin
        if (signal_out2 !== 1'b1) errs++;
        if (rx_pos == 10) begin
          total++;
          if (rx_byte !== rx_cnt[7:0]) begin
            bad++;
            $display("FAIL loop_byte n=%0d got=%h exp=%h",
                     rx_cnt, rx_byte, rx_cnt[7:0]);
          end
          rx_cnt++;
          rx_pos = 0;
        end else begin
          rx_pos++;
        end
      end
    end
    total++;
    if (rx_cnt != 256 || idx != 256) begin
      bad++;
      $display("FAIL loop_count rx=%0d sent=%0d exp=256", rx_cnt, idx);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL loop_framing errs=%0d exp=0", errs);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy2 !== 1'b0 || signal_out2 !== 1'b1) begin
      bad++;
      $display("FAIL loop_idle busy=%b line=%b exp 0/1", busy2, signal_out2);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_back_to_back;
    test_reset_mid;
    test_frame_end_accept;
    test_loopback;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
